streaming_dot_product: RTL and testbench
========================================

// Module: streaming_dot_product
// PURPOSE
//  Pipelined, handshaked inner-product engine; next generation of the combinational-multiply/adder-tree unit.
//  Consumes LANES element pairs per beat, accumulates over multi-beat vectors delimited by in_last.
//  Emits one result per vector; per-beat signed/unsigned mode. Sits between operand-fetch streams and GEMM result writeback.
// PARAMETERS
//  LANES   4   element pairs per beat; power of two, >=2
//  IN_W    8   element width (bits)
//  ACC_W   32  accumulator/result width; must be >= 2*IN_W+$clog2(LANES)
//  CNT_W   16  beat-counter width
// PORTS
//  clk        in   1            clock
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            beat valid
//  in_ready   out  1            engine can accept beat
//  in_a       in   LANES*IN_W   operand vector A, lane i at [i*IN_W +: IN_W]
//  in_b       in   LANES*IN_W   operand vector B, same packing
//  in_signed  in   1            1: lanes two's-complement; 0: unsigned (per beat)
//  in_last    in   1            beat is final chunk of current vector
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts result
//  out_data   out  ACC_W        dot product of whole vector
//  out_beats  out  CNT_W        beats accumulated into out_data (saturates at all-ones)
//  out_ovf    out  1            accumulator saturated (only with IPU_SATURATE_EN, else 0)
// BEHAVIOUR
//  - Reset: in_ready=0 while rst high, 1 after; out_valid=0, out_data=0, out_beats=0, out_ovf=0;
//    all pipeline valids, accumulator, beat counter and mid_vec cleared.
//  - Handshake on in_valid&in_ready / out_valid&out_ready. out_* stable while out_valid&!out_ready.
//  - Global stall = out_valid & !out_ready; in_ready = !stall. All stages advance only when !stall.
//  - Stage 0: LANES products, 2*IN_W wide, sign- or zero-extended per in_signed; {valid,last,signed} travel with data.
//  - Stages 1..L (L=$clog2(LANES)): registered pairwise adder tree, +1 bit per level; final extended to ACC_W per signed.
//  - Stage L+1 accumulator; state mid_vec (IDLE=0 / ACCUM=1):
//      IDLE  + valid beat: acc=sum, cnt=1;          last? emit, stay IDLE : ->ACCUM
//      ACCUM + valid beat: acc=acc+sum, cnt=cnt+1;  last? emit, ->IDLE   : stay
//    emit: out_data<=new acc, out_beats<=new cnt, out_valid<=1 in same edge.
//  - Latency: out_valid rises L+2 clocks after last-beat handshake (LANES=4: 4 clocks). Throughput 1 beat/clk.
//  - out_valid&out_ready with no new emit clears out_valid; with simultaneous emit, out_valid stays 1 with new data.
//  - Wrap: without macro, accumulation is modulo 2^ACC_W. Beat counter saturates at 2^CNT_W-1.
//  - in_signed sampled per beat; mixed modes within a vector legal, each beat uses its own mode.
//  - Reset mid-vector: partial accumulation and in-flight beats discarded; no output emitted.
//  - in_last on single beat = one-beat vector. Bubbles (in_valid=0) mid-vector don't disturb acc.
// CONFIGURATION
//  IPU_SATURATE_EN defined: accumulate clamps to signed [-2^(ACC_W-1), 2^(ACC_W-1)-1] when the
//    beat is signed, unsigned [0, 2^ACC_W-1] otherwise; out_ovf=1 if any clamp occurred in the vector
//    (sticky per vector, cleared on IDLE start).
//  Not defined: modulo wrap, out_ovf tied to 0, no clamp logic synthesised.
// STRUCTURE
//  Package ipu_pkg: function clog2-based LEVELS helper, typedef beat_meta_t {valid,last,is_signed},
//    acc_state_e {IDLE, ACCUM}, localparam PROD_W = 2*IN_W.
//  Sub-module ipu_pipe_adder_tree: registered adder tree carrying beat_meta_t alongside data with stall enable.
//  Top holds multiplier stage, accumulator FSM, counter, output register, stall logic.
// TESTING  (LANES=4, IN_W=8, ACC_W=32 unless noted)
//  1. a={1,2,3,4}, b={5,6,7,8}, unsigned, last=1 -> out_data=70, out_beats=1, out_valid 4 clocks after handshake.
//  2. 3 beats a=all 1, b=all 2, last on beat 3, bubble between beats 1/2 -> out_data=24, out_beats=3, single emit.
//  3. a={0xFF,0xFE,3,4}, b=all 5: signed -> 20; unsigned -> 2580 (two back-to-back vectors, both correct).
//  4. Hold out_ready=0 for 10 clocks with result pending -> in_ready=0, out_data stable; release -> next result follows.
//  5. 2 non-last beats, pulse rst, then one-beat vector a=all 1,b=all 1 -> out_data=4, out_beats=1, no stale output.
//  6. ACC_W=18, signed, 3 beats a=all 127,b=all 127 -> macro: out_data=131071, out_ovf=1; no macro: -68596 wrapped, out_ovf=0.

Source files
------------

// File: rtl/ipu_pkg.sv
// ipu_pkg: shared types and helpers for the streaming inner-product engine.
//   levels()      : adder-tree depth for a given lane count
//   beat_meta_t   : {valid, last, is_signed} carried alongside each beat
//   acc_state_e   : accumulator state (IDLE / ACCUM)
//   PROD_W        : product width for the default element width
package ipu_pkg;

  localparam int IN_W_DEFAULT = 8;
  localparam int PROD_W       = 2 * IN_W_DEFAULT;

  function automatic int levels(input int lanes);
    return $clog2(lanes);
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
    logic is_signed;
  } beat_meta_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/ipu_pipe_adder_tree.sv
// ipu_pipe_adder_tree: registered pairwise adder tree, one register level per
// tree level, with beat metadata delayed alongside. Products are extended to the
// full tree width per beat mode at the input, so every level adds at SW bits.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             advance enable (low = hold everything)
//   prod           LANES products, lane i at [i*PW +: PW]
//   meta_in        metadata of the beat in prod
//   sum            tree result, SW = PW + levels(LANES) bits
//   meta_out       metadata aligned with sum
module ipu_pipe_adder_tree
  import ipu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PW    = PROD_W,
  localparam int L    = levels(LANES),
  localparam int SW   = PW + L
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [LANES*PW-1:0]   prod,
  input  beat_meta_t            meta_in,
  output logic [SW-1:0]         sum,
  output beat_meta_t            meta_out
);

  // Heap layout: kid[0..LANES-2] are registered internal nodes (root at 0),
  // kid[LANES-1..2*LANES-2] are the extended input products.
  logic [SW-1:0] node [LANES-1];
  logic [SW-1:0] kid  [2*LANES-1];
  beat_meta_t    meta_q [L];

  always_comb begin
    for (int n = 0; n < 2*LANES-1; n++) kid[n] = '0;
    for (int n = 0; n < LANES-1; n++) kid[n] = node[n];
    for (int i = 0; i < LANES; i++) begin
      if (meta_in.is_signed) kid[LANES-1+i] = SW'($signed(prod[i*PW +: PW]));
      else                   kid[LANES-1+i] = SW'(prod[i*PW +: PW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < LANES-1; n++) node[n] <= '0;
      for (int k = 0; k < L; k++) meta_q[k] <= '0;
    end else if (en) begin
      for (int n = 0; n < LANES-1; n++) node[n] <= kid[2*n+1] + kid[2*n+2];
      meta_q[0] <= meta_in;
      for (int k = 1; k < L; k++) meta_q[k] <= meta_q[k-1];
    end
  end

  assign sum      = kid[0];
  assign meta_out = meta_q[L-1];

endmodule

// File: rtl/streaming_dot_product.sv
// streaming_dot_product: pipelined, handshaked inner-product engine.
// Multiplier stage -> registered adder tree -> accumulator/output stage.
// One result per vector (vector ends on in_last); latency levels(LANES)+2 clocks.
// Optional macro IPU_SATURATE_EN: clamping accumulation with sticky out_ovf;
// without it accumulation wraps modulo 2^ACC_W and out_ovf is 0.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            input beat handshake
//   in_a, in_b                   LANES operands each, lane i at [i*IN_W +: IN_W]
//   in_signed, in_last           per-beat mode, end-of-vector marker
//   out_valid/out_ready          result handshake
//   out_data, out_beats, out_ovf result, beat count (saturating), clamp flag
//
// Accumulator states:
//   state | meaning
//   IDLE  | no partial vector; next valid beat starts a new accumulation
//   ACCUM | mid-vector; valid beats add into acc_q
module streaming_dot_product
  import ipu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_a,
  input  logic [LANES*IN_W-1:0] in_b,
  input  logic                  in_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [CNT_W-1:0]      out_beats,
  output logic                  out_ovf
);

  localparam int L  = levels(LANES);
  localparam int PW = 2 * IN_W;
  localparam int SW = PW + L;

  logic stall, hs;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign hs       = in_valid & in_ready;

  // Stage 0: lane products. The low PW bits of a two's-complement product equal
  // the unsigned product of the sign-extended operands.
  logic [LANES*PW-1:0] prod_d, prod_q;
  beat_meta_t          m0_q;

  always_comb begin
    logic [PW-1:0] xa, xb;
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_signed) begin
        xa = {{IN_W{in_a[i*IN_W+IN_W-1]}}, in_a[i*IN_W +: IN_W]};
        xb = {{IN_W{in_b[i*IN_W+IN_W-1]}}, in_b[i*IN_W +: IN_W]};
      end else begin
        xa = {{IN_W{1'b0}}, in_a[i*IN_W +: IN_W]};
        xb = {{IN_W{1'b0}}, in_b[i*IN_W +: IN_W]};
      end
      prod_d[i*PW +: PW] = xa * xb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      m0_q   <= '0;
    end else if (!stall) begin
      prod_q <= prod_d;
      m0_q   <= '{valid: hs, last: in_last, is_signed: in_signed};
    end
  end

  logic [SW-1:0] tree_sum;
  beat_meta_t    tm;

  ipu_pipe_adder_tree #(
    .LANES (LANES),
    .PW    (PW)
  ) u_tree (
    .clk      (clk),
    .rst      (rst),
    .en       (~stall),
    .prod     (prod_q),
    .meta_in  (m0_q),
    .sum      (tree_sum),
    .meta_out (tm)
  );

  // Accumulator stage
  acc_state_e       state;
  logic [ACC_W-1:0] acc_q, base, beat_ext, acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             ovf_next;

  always_comb begin
    beat_ext = tm.is_signed ? ACC_W'($signed(tree_sum)) : ACC_W'(tree_sum);
    base     = (state == ACCUM) ? acc_q : '0;
    if (state == IDLE)  cnt_next = CNT_W'(1);
    else if (&cnt_q)    cnt_next = cnt_q;
    else                cnt_next = cnt_q + CNT_W'(1);
  end

`ifdef IPU_SATURATE_EN
  logic             ovf_q, out_ovf_q;
  logic [ACC_W:0]   wide;
  logic             clamp;

  // One extra bit of headroom detects overflow; clamp range follows the
  // current beat's mode.
  always_comb begin
    wide     = '0;
    clamp    = 1'b0;
    acc_next = '0;
    if (tm.is_signed) begin
      wide     = {base[ACC_W-1], base} + {beat_ext[ACC_W-1], beat_ext};
      clamp    = wide[ACC_W] ^ wide[ACC_W-1];
      acc_next = wide[ACC_W-1:0];
      if (clamp) acc_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      wide     = {1'b0, base} + {1'b0, beat_ext};
      clamp    = wide[ACC_W];
      acc_next = clamp ? '1 : wide[ACC_W-1:0];
    end
    ovf_next = clamp | ((state == ACCUM) & ovf_q);
  end

  assign out_ovf = out_ovf_q;
`else
  always_comb begin
    acc_next = base + beat_ext;
    ovf_next = 1'b0;
  end

  assign out_ovf = ovf_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
`ifdef IPU_SATURATE_EN
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
`endif
    end else if (!stall) begin
      if (out_ready) out_valid <= 1'b0;
      if (tm.valid) begin
        acc_q <= acc_next;
        cnt_q <= cnt_next;
`ifdef IPU_SATURATE_EN
        ovf_q <= ovf_next;
`endif
        if (tm.last) begin
          state     <= IDLE;
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_beats <= cnt_next;
`ifdef IPU_SATURATE_EN
          out_ovf_q <= ovf_next;
`endif
        end else begin
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_streaming_dot_product.sv
// Scoreboard bench: two engines (ACC_W=32/CNT_W=16 and ACC_W=18/CNT_W=2) share
// one input stream; a vector-level reference model fills one queue per engine
// and per-engine monitors pop and compare on each output handshake.
module tb_streaming_dot_product;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_signed = 1'b0, in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_data;
  logic [15:0] out_beats;
  logic        in_ready18, out_valid18, out_ovf18;
  logic [17:0] out_data18;
  logic [1:0]  out_beats18;

  always #5 clk = ~clk;

  streaming_dot_product #(.LANES(4), .IN_W(8), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_ovf(out_ovf));

  streaming_dot_product #(.LANES(4), .IN_W(8), .ACC_W(18), .CNT_W(2)) dut18 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready18),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid18), .out_ready(out_ready), .out_data(out_data18),
    .out_beats(out_beats18), .out_ovf(out_ovf18));

  typedef struct { logic [31:0] a; logic [31:0] b; bit sgn; } beat_t;
  typedef struct { longint data; int beats; bit ovf; } exp_t;

  int    checks = 0, errors = 0;
  int    cyc = 0, hs_cyc = 0, rise_cyc = -1;
  bit    rand_ready = 0;
  beat_t cur_vec[$];
  exp_t  q32[$], q18[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: dot product of each beat (per-beat mode), accumulated over the
  // vector; wrap or clamp at W bits; beat count saturates at 2^C-1.
  function automatic exp_t ref_vec(input beat_t v[$], input int W, input int C);
    longint acc = 0, base, s, val, lo, hi, m;
    bit     ovf = 0;
    exp_t   e;
    m = (longint'(1) << W) - 1;
    foreach (v[k]) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        int ai, bi;
        ai = int'(v[k].a[8*i +: 8]);
        bi = int'(v[k].b[8*i +: 8]);
        if (v[k].sgn && ai >= 128) ai -= 256;
        if (v[k].sgn && bi >= 128) bi -= 256;
        s += longint'(ai * bi);
      end
      if (k == 0) base = 0;
      else if (v[k].sgn && acc >= (longint'(1) << (W-1))) base = acc - (longint'(1) << W);
      else base = acc;
      val = base + s;
`ifdef IPU_SATURATE_EN
      if (v[k].sgn) begin
        lo = -(longint'(1) << (W-1));
        hi = (longint'(1) << (W-1)) - 1;
      end else begin
        lo = 0;
        hi = m;
      end
      if (val > hi) begin val = hi; ovf = 1; end
      else if (val < lo) begin val = lo; ovf = 1; end
`else
      lo = 0;
      hi = 0;
`endif
      acc = val & m;
    end
    e.data  = acc;
    e.beats = (v.size() > (1 << C) - 1) ? (1 << C) - 1 : v.size();
    e.ovf   = ovf;
    return e;
  endfunction

  // Monitors
  bit          held_valid = 0;
  logic [31:0] held_data;
  logic [15:0] held_beats;
  logic        held_ovf;
  bit          prev_valid = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (held_valid) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_beats !== held_beats || out_ovf !== held_ovf) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%0d beats=%0d ovf=%0b, required valid=1 data=%0d beats=%0d ovf=%0b",
                   out_valid, out_data, out_beats, out_ovf, held_data, held_beats, held_ovf);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL result32: unexpected output data=%0d beats=%0d, required none", out_data, out_beats);
        end else begin
          exp_t e;
          e = q32.pop_front();
          if (longint'(out_data) != e.data || int'(out_beats) != e.beats || out_ovf != e.ovf) begin
            errors++;
            $display("FAIL result32: got data=%0d beats=%0d ovf=%0b, required data=%0d beats=%0d ovf=%0b",
                     out_data, out_beats, out_ovf, e.data, e.beats, e.ovf);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      held_beats = out_beats;
      held_ovf   = out_ovf;
      prev_valid = out_valid;
    end else begin
      held_valid = 0;
      prev_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid18 && out_ready) begin
      checks++;
      if (q18.size() == 0) begin
        errors++;
        $display("FAIL result18: unexpected output data=%0d beats=%0d, required none", out_data18, out_beats18);
      end else begin
        exp_t e;
        e = q18.pop_front();
        if (longint'(out_data18) != e.data || int'(out_beats18) != e.beats || out_ovf18 != e.ovf) begin
          errors++;
          $display("FAIL result18: got data=%0d beats=%0d ovf=%0b, required data=%0d beats=%0d ovf=%0b",
                   out_data18, out_beats18, out_ovf18, e.data, e.beats, e.ovf);
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom % 4) != 0;
  end

  // Tasks start and end at posedge+1.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit last);
    int    n = 0;
    beat_t bt;
    in_a = a; in_b = b; in_signed = sgn; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, required 1", n);
    end
    checks++;
    if (in_ready18 !== in_ready) begin
      errors++;
      $display("FAIL in_ready18: got %0b, required %0b", in_ready18, in_ready);
    end
    @(posedge clk);
    #1;
    hs_cyc   = cyc;
    in_valid = 1'b0;
    bt.a = a; bt.b = b; bt.sgn = sgn;
    cur_vec.push_back(bt);
    if (last) begin
      q32.push_back(ref_vec(cur_vec, 32, 16));
      q18.push_back(ref_vec(cur_vec, 18, 2));
      cur_vec.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q18.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q32.size() != 0 || q18.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results pending, required 0", q32.size(), q18.size());
    end
  endtask

  task automatic check_reset_state();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_beats !== 16'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b valid=%0b data=%0d beats=%0d ovf=%0b, required all 0",
               in_ready, out_valid, out_data, out_beats, out_ovf);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cur_vec.delete();
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int nb;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 1: single-beat vector and latency
    send_beat(32'h04030201, 32'h08070605, 1'b0, 1'b1);
    drain();
    checks++;
    if (rise_cyc - hs_cyc != 3) begin
      errors++;
      $display("FAIL latency: got out_valid %0d edges after handshake edge, required 3", rise_cyc - hs_cyc);
    end

    // 2: three beats with a bubble
    send_beat(32'h01010101, 32'h02020202, 1'b0, 1'b0);
    idle(2);
    send_beat(32'h01010101, 32'h02020202, 1'b0, 1'b0);
    send_beat(32'h01010101, 32'h02020202, 1'b0, 1'b1);
    drain();

    // 3: same operands signed then unsigned, back to back
    send_beat(32'h0403FEFF, 32'h05050505, 1'b1, 1'b1);
    send_beat(32'h0403FEFF, 32'h05050505, 1'b0, 1'b1);
    drain();

    // 4: backpressure for 10 clocks with results pending
    out_ready = 1'b0;
    send_beat($urandom, $urandom, 1'b1, 1'b1);
    send_beat($urandom, $urandom, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready: got %0b, required 0", in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // 5: reset mid-vector, then a clean one-beat vector
    send_beat(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    send_beat(32'h33333333, 32'h44444444, 1'b1, 1'b0);
    do_reset();
    send_beat(32'h01010101, 32'h01010101, 1'b0, 1'b1);
    drain();

    // 6: signed overflow at ACC_W=18 (32-bit engine sees plain sum)
    for (int k = 0; k < 3; k++) send_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, k == 2);
    // beat-count saturation at CNT_W=2
    for (int k = 0; k < 5; k++) send_beat(32'h01020304, 32'h01010101, 1'b0, k == 4);
    drain();

    // Random phase: mixed modes, bubbles, random backpressure
    rand_ready = 1;
    for (int v = 0; v < 60; v++) begin
      nb = 1 + int'($urandom % 6);
      for (int k = 0; k < nb; k++) begin
        ra = $urandom;
        rb = $urandom;
        send_beat(ra, rb, 1'($urandom % 2), k == nb - 1);
        if ($urandom % 3 == 0) idle(1 + int'($urandom % 2));
      end
    end
    rand_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
